reg_write_back: RTL and testbench

//  Write-back stage of the LCA pipeline: the writer feeding register_file; reg read is its consumer.

---
 rtl/lca_pkg.sv | 11 +
 rtl/prio_enc8.sv | 13 +
 rtl/reg_write_back.sv | 127 ++++++++++++
 tb/tb_reg_write_back.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/lca_pkg.sv
// lca_pkg: shared op encodings, register constants and write-back FSM state type
package lca_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;
    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_SINGLE = 2'b01;
    localparam logic [1:0] OP_LM     = 2'b10;
    localparam logic [2:0] REG_PC    = 3'd7;
    typedef enum logic {IDLE, BURST} wb_state_t;
endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: index of the lowest set bit of an 8-bit mask (mask -> idx, any = mask non-zero)
module prio_enc8 (
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic       any
);
    always_comb begin
        idx = '0;
        for (int i = 7; i >= 0; i--)
            if (mask[i]) idx = 3'(i);
    end
    assign any = |mask;
endmodule

// File: rtl/reg_write_back.sv
// reg_write_back: LCA write-back stage driving register_file; sequences LM bursts, optional bypass (WB_FWD_EN)
// Ports: clk, reset (sync, active-low); in_valid/in_ready/in_op/in_dest/in_data/in_mask/in_pc from MEM;
//        lm_data_valid/lm_data/lm_data_ready for burst words; write/writeAdd/wrData/writeR7/inR7 to
//        register_file; busy stall flag; fwd_valid/fwd_add/fwd_data bypass (zero unless WB_FWD_EN).
module reg_write_back
    import lca_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [ADDR_W_P-1:0] in_dest,
    input  logic [DATA_W_P-1:0] in_data,
    input  logic [7:0]          in_mask,
    input  logic [DATA_W_P-1:0] in_pc,
    input  logic                lm_data_valid,
    input  logic [DATA_W_P-1:0] lm_data,
    output logic                lm_data_ready,
    output logic                write,
    output logic [ADDR_W_P-1:0] writeAdd,
    output logic [DATA_W_P-1:0] wrData,
    output logic                writeR7,
    output logic [DATA_W_P-1:0] inR7,
    output logic                busy,
    output logic                fwd_valid,
    output logic [ADDR_W_P-1:0] fwd_add,
    output logic [DATA_W_P-1:0] fwd_data
);
    wb_state_t           state_q, state_d;
    logic [7:0]          mask_q, mask_d;
    logic                write_q, write_d, write_r7_q, write_r7_d;
    logic [ADDR_W_P-1:0] write_add_q, write_add_d;
    logic [DATA_W_P-1:0] wr_data_q, wr_data_d, in_r7_q, in_r7_d;
    logic [2:0]          idx;
    logic                any;

    prio_enc8 u_enc (.mask(mask_q), .idx(idx), .any(any));

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        write_d     = 1'b0;
        write_add_d = '0;
        wr_data_d   = '0;
        write_r7_d  = 1'b0;
        in_r7_d     = '0;
        if (state_q == IDLE && in_valid && in_op != 2'b11) begin
            in_r7_d = in_pc;
            // Loaded data owns R7 when the instruction itself targets it.
            write_r7_d = (in_op == OP_SINGLE) ? (in_dest != ADDR_W_P'(REG_PC)) :
                         (in_op == OP_LM)     ? !in_mask[7] : 1'b1;
            if (in_op == OP_SINGLE) begin
                write_d     = 1'b1;
                write_add_d = in_dest;
                wr_data_d   = in_data;
            end
            if (in_op == OP_LM && in_mask != '0) begin
                mask_d  = in_mask;
                state_d = BURST;
            end
        end else if (state_q == BURST && lm_data_valid && any) begin
            write_d     = 1'b1;
            write_add_d = ADDR_W_P'(idx);
            wr_data_d   = lm_data;
            mask_d      = mask_q & ~(8'd1 << idx);
            state_d     = (mask_d == '0) ? IDLE : BURST;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            write_q     <= 1'b0;
            write_add_q <= '0;
            wr_data_q   <= '0;
            write_r7_q  <= 1'b0;
            in_r7_q     <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            write_q     <= write_d;
            write_add_q <= write_add_d;
            wr_data_q   <= wr_data_d;
            write_r7_q  <= write_r7_d;
            in_r7_q     <= in_r7_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign lm_data_ready = (state_q == BURST);
    assign busy          = (state_q == BURST);
    assign write         = write_q;
    assign writeAdd      = write_add_q;
    assign wrData        = wr_data_q;
    assign writeR7       = write_r7_q;
    assign inR7          = in_r7_q;

`ifdef WB_FWD_EN
    logic                fwd_valid_q;
    logic [ADDR_W_P-1:0] fwd_add_q;
    logic [DATA_W_P-1:0] fwd_data_q;
    // Loaded from the same next values as the write port so both appear together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fwd_valid_q <= 1'b0;
            fwd_add_q   <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= write_d;
            fwd_add_q   <= write_add_d;
            fwd_data_q  <= wr_data_d;
        end
    end
    assign fwd_valid = fwd_valid_q;
    assign fwd_add   = fwd_add_q;
    assign fwd_data  = fwd_data_q;
`else
    assign fwd_valid = 1'b0;
    assign fwd_add   = '0;
    assign fwd_data  = '0;
`endif
endmodule

// File: tb/tb_reg_write_back.sv
// tb_reg_write_back: randomized + directed check of reg_write_back against a queue-based model
module tb_reg_write_back;
    logic        clk = 0, reset = 0, in_valid = 0, lm_data_valid = 0;
    logic [1:0]  in_op = 0;
    logic [2:0]  in_dest = 0;
    logic [15:0] in_data = 0, in_pc = 0, lm_data = 0;
    logic [7:0]  in_mask = 0;
    logic        in_ready, lm_data_ready, write, writeR7, busy, fwd_valid;
    logic [2:0]  writeAdd, fwd_add;
    logic [15:0] wrData, inR7, fwd_data;

    reg_write_back dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dest(in_dest), .in_data(in_data), .in_mask(in_mask), .in_pc(in_pc),
        .lm_data_valid(lm_data_valid), .lm_data(lm_data), .lm_data_ready(lm_data_ready),
        .write(write), .writeAdd(writeAdd), .wrData(wrData), .writeR7(writeR7), .inR7(inR7),
        .busy(busy), .fwd_valid(fwd_valid), .fwd_add(fwd_add), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int pend[$];
    bit chk_en = 0;
    logic        e_write, e_w7, e_busy;
    logic [2:0]  e_add;
    logic [15:0] e_data, e_r7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: apply inputs, advance the model, then let the edge happen.
    task automatic cyc(input logic r, input logic v, input logic [1:0] op, input logic [2:0] d,
                       input logic [15:0] dt, input logic [7:0] m, input logic [15:0] p,
                       input logic lv, input logic [15:0] ld);
        @(negedge clk);
        reset = r; in_valid = v; in_op = op; in_dest = d; in_data = dt; in_mask = m;
        in_pc = p; lm_data_valid = lv; lm_data = ld;
        e_write = 0; e_add = 0; e_data = 0; e_w7 = 0; e_r7 = 0;
        if (!r) pend.delete();
        else if (pend.size() == 0) begin
            if (v && op != 2'b11) begin
                e_r7 = p;
                if (op == 2'b01) begin
                    e_write = 1; e_add = d; e_data = dt; e_w7 = (d != 7);
                end else if (op == 2'b10) begin
                    for (int i = 0; i < 8; i++) if (m[i]) pend.push_back(i);
                    e_w7 = !m[7];
                end else e_w7 = 1;
            end
        end else if (lv) begin
            e_write = 1; e_add = 3'(pend.pop_front()); e_data = ld;
        end
        e_busy = pend.size() != 0;
        chk_en = 1;
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("write", write, e_write);
            chk("writeAdd", writeAdd, e_add);
            chk("wrData", wrData, e_data);
            chk("writeR7", writeR7, e_w7);
            chk("inR7", inR7, e_r7);
            chk("busy", busy, e_busy);
            chk("in_ready", in_ready, !e_busy);
            chk("lm_data_ready", lm_data_ready, e_busy);
`ifdef WB_FWD_EN
            chk("fwd_valid", fwd_valid, e_write);
            chk("fwd_add", fwd_add, e_add);
            chk("fwd_data", fwd_data, e_data);
`else
            chk("fwd_valid", fwd_valid, 0);
            chk("fwd_add", fwd_add, 0);
            chk("fwd_data", fwd_data, 0);
`endif
        end
    end

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_ready", in_ready, 1);
        // Reset in the middle of an LM burst.
        cyc(1, 1, 2'b10, 0, 0, 8'h0F, 16'h0100, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 16'h1111);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 16'h2222);
        chk("mid_burst_busy", busy, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 16'h3333);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 16'h4444);
        chk("rst_write", write, 0);
        chk("rst_ready", in_ready, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 16'h5555);
        chk("post_rst_nowrite", write, 0);
        // SINGLE to R3.
        cyc(1, 1, 2'b01, 3, 16'hBEEF, 0, 16'h0012, 0, 0);
        chk("s_write", write, 1);
        chk("s_add", writeAdd, 3);
        chk("s_data", wrData, 16'hBEEF);
        chk("s_w7", writeR7, 1);
        chk("s_r7", inR7, 16'h0012);
        // LM 1010_0101 with a gap after the second word.
        cyc(1, 1, 2'b10, 0, 0, 8'b1010_0101, 16'h0020, 0, 0);
        chk("lm_w7", writeR7, 0);
        cyc(1, 1, 2'b01, 1, 16'hDEAD, 0, 0, 1, 16'h00A1);
        chk("lm_a1_add", writeAdd, 0);
        chk("lm_a1_data", wrData, 16'h00A1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 16'h00A2);
        chk("lm_a2_add", writeAdd, 2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'h0099);
        chk("lm_gap", write, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 16'h00A3);
        chk("lm_a3_add", writeAdd, 5);
        chk("lm_still_busy", in_ready, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 16'h00A4);
        chk("lm_a4_add", writeAdd, 7);
        chk("lm_a4_data", wrData, 16'h00A4);
        chk("lm_a4_w7", writeR7, 0);
        chk("lm_done_ready", in_ready, 1);
        // SINGLE to R7, then empty LM.
        cyc(1, 1, 2'b01, 7, 16'h0040, 0, 16'h0030, 0, 0);
        chk("r7_add", writeAdd, 7);
        chk("r7_data", wrData, 16'h0040);
        chk("r7_w7", writeR7, 0);
        cyc(1, 1, 2'b10, 0, 0, 8'h00, 16'h0034, 0, 0);
        chk("lm0_write", write, 0);
        chk("lm0_w7", writeR7, 1);
        chk("lm0_r7", inR7, 16'h0034);
        chk("lm0_ready", in_ready, 1);
        // Back-to-back SINGLEs.
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 1, 2'b01, 3'(i), 16'(16'h1000 * i), 0, 16'(i), 0, 0);
            chk("b2b_write", write, 1);
            chk("b2b_add", writeAdd, i);
            chk("b2b_ready", in_ready, 1);
        end
        // Random traffic.
        for (int n = 0; n < 600; n++)
            cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), 2'($urandom),
                3'($urandom), 16'($urandom), (($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom)),
                16'($urandom), ($urandom_range(0, 9) < 7), 16'($urandom));
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
